// File: rtl/eu_pipe_if.sv
// Bus bundle for eu_pipe: instruction handshake, data-memory port and writeback port.
// The slave modport is the execution unit; the master drives instructions and models memory.
interface eu_pipe_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 4
);
    // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
    // the master holds every instruction field stable while in_valid=1 and in_ready=0.
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [REG_AW-1:0] dest_reg;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] operandA;
    logic [DATA_W-1:0] operandB;

    logic              mem_re;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        flags;

    logic              dbg_state;

    modport slave (
        input  in_valid, opcode, dest_reg, mem_addr, operandA, operandB,
        input  mem_rdata, mem_rvalid,
        output in_ready, mem_re, mem_we, mem_addr_out, mem_wdata,
        output wb_valid, wb_reg, wb_data, flags, dbg_state
    );

    modport master (
        output in_valid, opcode, dest_reg, mem_addr, operandA, operandB,
        output mem_rdata, mem_rvalid,
        input  in_ready, mem_re, mem_we, mem_addr_out, mem_wdata,
        input  wb_valid, wb_reg, wb_data, flags, dbg_state
    );
endinterface

// File: rtl/eu_pipe.sv
// Registered execution unit: single-cycle ALU writeback, STORE write strobe,
// and LOAD with a variable-latency memory read that stalls the front end.
module eu_pipe #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 4
) (
    input logic      clk,
    input logic      reset,
    eu_pipe_if.slave bus
);
    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_INC   = 4'h6;
    localparam logic [3:0] OP_DEC   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_NEG   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_SHL   = 4'hB;
    localparam logic [3:0] OP_ROR   = 4'hC;
    localparam logic [3:0] OP_ROL   = 4'hD;
    localparam logic [3:0] OP_LOAD  = 4'hE;
    localparam logic [3:0] OP_STORE = 4'hF;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_accept;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_ext;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic              w_is_alu;
    logic [3:0]        w_flags;

    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_reg;
    logic [DATA_W-1:0] r_wb_data;
    logic [3:0]        r_flags;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr_out;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [REG_AW-1:0] r_load_reg;

    assign w_a          = bus.operandA;
    assign w_b          = bus.operandB;
    assign bus.in_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // mem_rvalid is honoured from the mem_re cycle onward, so zero-wait memory works.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (bus.opcode == OP_LOAD)) begin
                    w_state_nxt = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Subtract-type ops take C as borrow, i.e. the extended bit of the wrapped difference.
    always_comb begin
        w_ext    = '0;
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_is_alu = 1'b1;
        case (bus.opcode)
            OP_ADD: begin
                w_ext = {1'b0, w_a} + {1'b0, w_b};
                w_res = w_ext[MSB:0];
                w_c   = w_ext[DATA_W];
                w_v   = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
            end
            OP_SUB: begin
                w_ext = {1'b0, w_a} - {1'b0, w_b};
                w_res = w_ext[MSB:0];
                w_c   = w_ext[DATA_W];
                w_v   = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
            end
            OP_INC: begin
                w_ext = {1'b0, w_a} + {1'b0, ONE};
                w_res = w_ext[MSB:0];
                w_c   = w_ext[DATA_W];
                w_v   = !w_a[MSB] && w_res[MSB];
            end
            OP_DEC: begin
                w_ext = {1'b0, w_a} - {1'b0, ONE};
                w_res = w_ext[MSB:0];
                w_c   = w_ext[DATA_W];
                w_v   = w_a[MSB] && !w_res[MSB];
            end
            OP_NEG: begin
                w_ext = {(DATA_W+1){1'b0}} - {1'b0, w_a};
                w_res = w_ext[MSB:0];
                w_c   = w_ext[DATA_W];
                w_v   = w_a[MSB] && w_res[MSB];
            end
            OP_AND: w_res = w_a & w_b;
            OP_OR:  w_res = w_a | w_b;
            OP_XOR: w_res = w_a ^ w_b;
            OP_NOT: w_res = ~w_a;
            OP_SHR: begin
                w_res = {1'b0, w_a[MSB:1]};
                w_c   = w_a[0];
            end
            OP_SHL: begin
                w_res = {w_a[MSB-1:0], 1'b0};
                w_c   = w_a[MSB];
            end
            OP_ROR: begin
                w_res = {w_a[0], w_a[MSB:1]};
                w_c   = w_a[0];
            end
            OP_ROL: begin
                w_res = {w_a[MSB-1:0], w_a[MSB]};
                w_c   = w_a[MSB];
            end
            default: w_is_alu = 1'b0;
        endcase
    end

    assign w_flags = {(w_res == '0), w_res[MSB], w_c, w_v};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg       <= '0;
            r_wb_data      <= '0;
            r_flags        <= '0;
            r_mem_re       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr_out <= '0;
            r_mem_wdata    <= '0;
            r_load_reg     <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            if (w_accept) begin
                if (w_is_alu) begin
                    r_wb_valid <= 1'b1;
                    r_wb_reg   <= bus.dest_reg;
                    r_wb_data  <= w_res;
                    r_flags    <= w_flags;
                end else if (bus.opcode == OP_LOAD) begin
                    r_mem_re       <= 1'b1;
                    r_mem_addr_out <= bus.mem_addr;
                    r_load_reg     <= bus.dest_reg;
                end else if (bus.opcode == OP_STORE) begin
                    r_mem_we       <= 1'b1;
                    r_mem_addr_out <= bus.mem_addr;
                    r_mem_wdata    <= bus.operandA;
                end
            end
            if ((r_state == ST_WAIT_MEM) && bus.mem_rvalid) begin
                r_wb_valid <= 1'b1;
                r_wb_reg   <= r_load_reg;
                r_wb_data  <= bus.mem_rdata;
            end
        end
    end

    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_reg       = r_wb_reg;
    assign bus.wb_data      = r_wb_data;
    assign bus.flags        = r_flags;
    assign bus.mem_re       = r_mem_re;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr_out = r_mem_addr_out;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.dbg_state    = (r_state == ST_WAIT_MEM);
endmodule

// File: tb/tb_eu_pipe.sv
// Self-checking bench for eu_pipe: directed scenarios plus a randomized run
// checked against an integer-arithmetic reference model and a writeback queue.
module tb_eu_pipe;
    localparam int DATA_W = 8;
    localparam int REG_AW = 3;
    localparam int MEM_AW = 4;
    localparam int WB_W   = REG_AW + DATA_W;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic [3:0]      exp_flags;
    logic [WB_W-1:0] exp_q[$];

    eu_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) bus ();

    eu_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Signed/unsigned integer reference for the ALU opcodes; returns result and {Z,N,C,V}.
    function automatic void model_alu(input logic [3:0] op, input int a, input int b,
                                      output int res, output logic [3:0] fl);
        int r, sa, sb, s;
        bit c, v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = 0; s = 0; c = 0; v = 0;
        case (op)
            4'h1: begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            4'h2: begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127) || (s < -128); end
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            4'h6: begin r = a + 1; c = (r > 255); s = sa + 1; v = (s > 127); end
            4'h7: begin r = a - 1; c = (a < 1);   s = sa - 1; v = (s < -128); end
            4'h8: r = 255 - a;
            4'h9: begin r = -a; c = (a > 0); s = -sa; v = (s > 127); end
            4'hA: begin r = a / 2; c = (a % 2) == 1; end
            4'hB: begin r = a * 2; c = (a >= 128); end
            4'hC: begin r = a / 2 + (a % 2) * 128; c = (a % 2) == 1; end
            4'hD: begin r = a * 2 + a / 128; c = (a >= 128); end
            default: r = 0;
        endcase
        res = ((r % 256) + 256) % 256;
        fl  = {res == 0, res >= 128, c, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [REG_AW-1:0] dest,
                         input logic [MEM_AW-1:0] addr, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.dest_reg = dest;
        bus.mem_addr = addr;
        bus.operandA = a;
        bus.operandB = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'h1, 3'd1, 4'h0, 8'h11, 8'h22);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
            n_cmp++; if ({bus.wb_valid, bus.mem_re, bus.mem_we} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {bus.wb_valid, bus.mem_re, bus.mem_we}); end
            n_cmp++; if (bus.flags !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", bus.flags); end
        end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        exp_flags = 4'h0;
        step();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL release_wb_valid: got %b want 0", bus.wb_valid); end
    endtask

    task automatic test_add_sub();
        drive(4'h1, 3'd2, 4'h0, 8'h7F, 8'h01);
        step();
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL add_wb_valid: got %b want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_reg !== 3'd2) begin n_err++; $display("FAIL add_wb_reg: got %0d want 2", bus.wb_reg); end
        n_cmp++; if (bus.wb_data !== 8'h80) begin n_err++; $display("FAIL add_wb_data: got %h want 80", bus.wb_data); end
        n_cmp++; if (bus.flags !== 4'b0101) begin n_err++; $display("FAIL add_flags: got %b want 0101", bus.flags); end
        drive(4'h2, 3'd4, 4'h0, 8'h03, 8'h05);
        step();
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL sub_wb_valid: got %b want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_reg !== 3'd4) begin n_err++; $display("FAIL sub_wb_reg: got %0d want 4", bus.wb_reg); end
        n_cmp++; if (bus.wb_data !== 8'hFE) begin n_err++; $display("FAIL sub_wb_data: got %h want fe", bus.wb_data); end
        n_cmp++; if (bus.flags !== 4'b0110) begin n_err++; $display("FAIL sub_flags: got %b want 0110", bus.flags); end
        bus.in_valid = 1'b0;
        exp_flags = 4'b0110;
        step();
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL sub_wb_pulse: got %b want 0", bus.wb_valid); end
    endtask

    task automatic test_load();
        drive(4'hE, 3'd5, 4'hA, 8'h00, 8'h00);
        step();
        n_cmp++; if (bus.mem_re !== 1'b1) begin n_err++; $display("FAIL load_mem_re: got %b want 1", bus.mem_re); end
        n_cmp++; if (bus.mem_addr_out !== 4'hA) begin n_err++; $display("FAIL load_addr: got %h want a", bus.mem_addr_out); end
        // A held ADD waits upstream for the whole load.
        drive(4'h1, 3'd3, 4'h0, 8'h01, 8'h02);
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid = (k == 3);
            bus.mem_rdata  = (k == 3) ? 8'hAB : 8'($urandom_range(0, 255));
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL load_stall_%0d: in_ready got %b want 0", k, bus.in_ready); end
            n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL load_no_wb_%0d: got %b want 0", k, bus.wb_valid); end
            if (k > 0) begin
                n_cmp++; if (bus.mem_re !== 1'b0) begin n_err++; $display("FAIL load_re_pulse_%0d: got %b want 0", k, bus.mem_re); end
            end
            step();
        end
        bus.mem_rvalid = 1'b0;
        n_cmp++; if ({bus.wb_valid, bus.wb_reg, bus.wb_data} !== {1'b1, 3'd5, 8'hAB}) begin n_err++; $display("FAIL load_wb: got v%b r%0d d%h want v1 r5 dab", bus.wb_valid, bus.wb_reg, bus.wb_data); end
        n_cmp++; if (bus.flags !== exp_flags) begin n_err++; $display("FAIL load_flags: got %b want %b", bus.flags, exp_flags); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_back: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if ({bus.wb_valid, bus.wb_reg, bus.wb_data} !== {1'b1, 3'd3, 8'h03}) begin n_err++; $display("FAIL held_add_wb: got v%b r%0d d%h want v1 r3 d03", bus.wb_valid, bus.wb_reg, bus.wb_data); end
        exp_flags = 4'b0000;
        n_cmp++; if (bus.flags !== exp_flags) begin n_err++; $display("FAIL held_add_flags: got %b want 0000", bus.flags); end
    endtask

    task automatic test_store();
        drive(4'hF, 3'd1, 4'hA, 8'h5C, 8'h00);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if ({bus.mem_we, bus.mem_addr_out, bus.mem_wdata} !== {1'b1, 4'hA, 8'h5C}) begin n_err++; $display("FAIL store_write: got we%b a%h d%h want we1 aa d5c", bus.mem_we, bus.mem_addr_out, bus.mem_wdata); end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL store_no_wb: got %b want 0", bus.wb_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL store_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.flags !== exp_flags) begin n_err++; $display("FAIL store_flags: got %b want %b", bus.flags, exp_flags); end
        step();
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL store_pulse: got %b want 0", bus.mem_we); end
    endtask

    task automatic test_shift_rot();
        logic [3:0] ops[6]  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h9, 4'h7};
        logic [7:0] ain[6]  = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h80, 8'h00};
        logic [7:0] want[6] = '{8'h55, 8'h54, 8'h55, 8'h55, 8'h80, 8'hFF};
        logic       cw[6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], 3'(i), 4'h0, ain[i], 8'h00);
            step();
            n_cmp++; if (bus.wb_data !== want[i]) begin n_err++; $display("FAIL shrot_data_%0d: got %h want %h", i, bus.wb_data, want[i]); end
            n_cmp++; if (bus.flags[1] !== cw[i]) begin n_err++; $display("FAIL shrot_c_%0d: got %b want %b", i, bus.flags[1], cw[i]); end
            if (i == 4) begin
                n_cmp++; if (bus.flags[0] !== 1'b1) begin n_err++; $display("FAIL neg_v: got %b want 1", bus.flags[0]); end
            end
        end
        bus.in_valid = 1'b0;
        exp_flags = 4'b0110;
        step();
    endtask

    task automatic test_reset_in_wait();
        drive(4'hE, 3'd6, 4'h3, 8'h00, 8'h00);
        step();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        n_cmp++; if ({bus.wb_valid, bus.mem_re, bus.mem_we, bus.flags} !== 7'b0) begin n_err++; $display("FAIL rstwait_outputs: got %b want 0", {bus.wb_valid, bus.mem_re, bus.mem_we, bus.flags}); end
        n_cmp++; if ({bus.mem_addr_out, bus.wb_data} !== 12'h0) begin n_err++; $display("FAIL rstwait_data: got %h want 000", {bus.mem_addr_out, bus.wb_data}); end
        reset = 1'b0;
        exp_flags = 4'h0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rstwait_ready: got %b want 1", bus.in_ready); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'h77;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rstwait_dropped_%0d: got %b want 0", k, bus.wb_valid); end
        end
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [REG_AW-1:0] dest;
        logic [MEM_AW-1:0] addr;
        logic [DATA_W-1:0] a, b, rd;
        logic [WB_W-1:0] got, exp_e;
        logic [3:0] fl;
        int res, lat;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.in_valid   = 1'b0;
                bus.mem_rvalid = 1'($urandom_range(0, 1));
                step();
                bus.mem_rvalid = 1'b0;
                n_cmp++; if ({bus.wb_valid, bus.mem_re, bus.mem_we} !== 3'b000) begin n_err++; $display("FAIL rnd_idle_%0d: strobes %b want 000", it, {bus.wb_valid, bus.mem_re, bus.mem_we}); end
                continue;
            end
            op   = 4'($urandom_range(0, 15));
            dest = 3'($urandom_range(0, 7));
            addr = 4'($urandom_range(0, 15));
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) a = 8'h80;
            drive(op, dest, addr, a, b);
            step();
            bus.in_valid = 1'b0;
            if (op >= 4'h1 && op <= 4'hD) begin
                model_alu(op, int'(a), int'(b), res, fl);
                exp_q.push_back({dest, 8'(res)});
                exp_flags = fl;
            end else if (op == 4'hE) begin
                n_cmp++; if ({bus.mem_re, bus.mem_addr_out} !== {1'b1, addr}) begin n_err++; $display("FAIL rnd_load_req_%0d: got re%b a%h want re1 a%h", it, bus.mem_re, bus.mem_addr_out, addr); end
                lat = $urandom_range(0, 3);
                for (int k = 0; k <= lat; k++) begin
                    rd = 8'($urandom_range(0, 255));
                    bus.mem_rvalid = (k == lat);
                    bus.mem_rdata  = rd;
                    if (k == lat) exp_q.push_back({dest, rd});
                    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rnd_load_stall_%0d: got %b want 0", it, bus.in_ready); end
                    step();
                end
                bus.mem_rvalid = 1'b0;
            end
            if (op == 4'hF) begin
                n_cmp++; if ({bus.mem_we, bus.mem_addr_out, bus.mem_wdata} !== {1'b1, addr, a}) begin n_err++; $display("FAIL rnd_store_%0d: got we%b a%h d%h want we1 a%h d%h", it, bus.mem_we, bus.mem_addr_out, bus.mem_wdata, addr, a); end
            end
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                got   = {bus.wb_reg, bus.wb_data};
                n_cmp++; if (bus.wb_valid !== 1'b1 || got !== exp_e) begin n_err++; $display("FAIL rnd_wb_%0d op%h: got v%b %h want v1 %h", it, op, bus.wb_valid, got, exp_e); end
            end else begin
                n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rnd_no_wb_%0d op%h: got %b want 0", it, op, bus.wb_valid); end
            end
            n_cmp++; if (bus.flags !== exp_flags) begin n_err++; $display("FAIL rnd_flags_%0d op%h a%h b%h: got %b want %b", it, op, a, b, bus.flags, exp_flags); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_flags = 4'h0;
        reset = 1'b1;
        bus.in_valid   = 1'b0;
        bus.opcode     = 4'h0;
        bus.dest_reg   = '0;
        bus.mem_addr   = '0;
        bus.operandA   = '0;
        bus.operandB   = '0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;
        step();
        test_reset();
        test_add_sub();
        test_load();
        test_store();
        test_shift_rot();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/eu_pipe.md
Name: eu_pipe

Overview:
Parametrised, registered execution unit for the processor datapath. It accepts one decoded instruction per cycle over a valid/ready handshake. ALU results and flags are produced with one-cycle latency. LOAD uses a variable-latency data-memory read handshake and stalls the front end until read data returns. STORE issues a one-cycle write strobe. The block sits between the register-read stage and the register-file write port / data memory.

Parameters:
DATA_W, 8, operand/result width (>=4)
REG_AW, 3, register address width
MEM_AW, 4, data memory address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  instruction present
in_ready  out  1  unit can accept this cycle
opcode  in  4  0000 NOP, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 INC, 0111 DEC, 1000 NOT, 1001 NEG, 1010 SHR, 1011 SHL, 1100 ROR, 1101 ROL, 1110 LOAD, 1111 STORE
dest_reg  in  REG_AW  writeback register
mem_addr  in  MEM_AW  LOAD/STORE address
operandA  in  DATA_W  source A; also STORE data
operandB  in  DATA_W  source B
mem_re  out  1  read strobe, one-cycle pulse
mem_we  out  1  write strobe, one-cycle pulse
mem_addr_out  out  MEM_AW  memory address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data
mem_rvalid  in  1  mem_rdata valid
wb_valid  out  1  writeback strobe, one-cycle pulse
wb_reg  out  REG_AW  writeback register
wb_data  out  DATA_W  writeback value
flags  out  4  {Z,N,C,V}

Behaviour:
- States: IDLE, WAIT_MEM. Accept means in_valid && in_ready at a rising edge.
- in_ready = 1 in IDLE when reset is low; 0 in WAIT_MEM; 0 while reset is high.
- Reset (any state, including mid-LOAD): state goes to IDLE. All outputs and flags go to 0. A pending load is dropped.
- ALU op accepted at edge T: wb_valid=1 for exactly one cycle after T, carrying wb_reg=dest_reg and wb_data=result. flags are updated on the same edge. Back-to-back ALU ops sustain one per cycle.
- Arithmetic is modulo 2^DATA_W.
  - INC = A+1. DEC = A-1. NEG = 0-A. NOT = ~A.
  - SHR/SHL are logical shifts by 1. ROR/ROL are rotates by 1.
- Z = (result==0). N = result MSB.
- C:
  - ADD/INC: carry out.
  - SUB/DEC/NEG: borrow (unsigned A < subtrahend).
  - SHR/ROR: A[0]. SHL/ROL: A[MSB].
  - Logic ops: 0.
- V (two's-complement overflow):
  - ADD/INC/SUB/DEC: signed overflow.
  - NEG: 1 iff A = 100...0.
  - All other ops: 0.
- NOP: accepted, no strobe, flags unchanged.
- STORE accepted at T: for one cycle after T, mem_we=1, mem_addr_out=mem_addr, mem_wdata=operandA. No wb_valid, flags unchanged, in_ready stays 1.
- LOAD accepted at T, in the cycle after T:
  - mem_re=1 for one cycle, mem_addr_out=mem_addr, state enters WAIT_MEM.
  - dest_reg is captured internally.
- In WAIT_MEM, mem_rvalid is sampled every cycle, including the mem_re cycle.
  - On the edge where mem_rvalid=1: wb_valid=1 for one cycle with wb_reg=captured dest and wb_data=mem_rdata; state returns to IDLE.
  - LOAD leaves flags unchanged.
- mem_rvalid in IDLE is ignored. in_valid during WAIT_MEM is not accepted; upstream holds the instruction.
- Outputs not being strobed hold their last values. Strobes are 0 otherwise.

Test Plan:
- Reset, then release:
  - While reset=1: in_ready=0, all strobes 0, flags=0000.
  - After release: in_ready=1 next cycle.
- ADD then SUB, back-to-back (DATA_W=8):
  - ADD A=7F, B=01, dest=2: one cycle later wb_valid=1, wb_reg=2, wb_data=80, flags Z0 N1 C0 V1.
  - SUB A=03, B=05 on the next cycle: wb_data=FE, flags N1 C1 V0.
- LOAD mem_addr=A, dest=5, memory answers 3 cycles after mem_re with AB:
  - mem_re pulses once with addr A; in_ready=0 for 4 cycles.
  - A held ADD is not accepted during the wait.
  - wb_valid=1 with reg 5, data AB; flags unchanged.
- STORE mem_addr=A, A=5C:
  - Single mem_we pulse with addr A, wdata 5C; no wb_valid; in_ready stays 1.
- Shifts/rotates with A=AA:
  - SHR -> 55, C=0. SHL -> 54, C=1. ROR -> 55, C=0. ROL -> 55, C=1.
  - NEG A=80 -> 80, V=1. DEC A=00 -> FF, C=1.
- Reset asserted in WAIT_MEM:
  - Next cycle: IDLE, in_ready=1.
  - A later mem_rvalid=1 produces no wb_valid.
